// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice.
// Contents: FSM state encoding, opcode/funct constants, datapath mux
// select codes, ALUOp class codes and small opcode classification helpers.
package multi_cycle_control_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct codes (IR[5:0]) for R-type
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // PCSource
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REGA  = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // RegDst
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // MemtoReg
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALUOp class codes (ALUOp[2:0])
  localparam logic [2:0] ALUC_ADD   = 3'b000;
  localparam logic [2:0] ALUC_BEQ   = 3'b001;
  localparam logic [2:0] ALUC_RTYPE = 3'b010;
  localparam logic [2:0] ALUC_ANDI  = 3'b100;
  localparam logic [2:0] ALUC_SLT   = 3'b101;
  localparam logic [2:0] ALUC_MUL   = 3'b110;

  function automatic logic isImmAlu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_SLTIU) || (op == OP_ANDI) || (op == OP_LUI);
  endfunction

  function automatic logic isDecoded(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) ||
           (op == OP_BEQ) || (op == OP_MUL) || (op == OP_LW) ||
           (op == OP_SW) || isImmAlu(op);
  endfunction

endpackage

// File: rtl/multi_cycle_control_alu_op_decode.sv
// mc_alu_op_decode: combinational opcode -> ALUOp class decode, shared with
// the single-cycle decoder.
// Ports:
//   OpCode  in   IR[31:26]
//   ALUOp   out  [2:0] class code, [3] = OpCode[0], upper bits zero
module mc_alu_op_decode
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4
) (
  input  logic [5:0]         OpCode,
  output logic [ALUOP_W-1:0] ALUOp
);

  logic [2:0] aluClass;

  always_comb begin
    aluClass = ALUC_ADD;
    case (OpCode)
      OP_RTYPE:          aluClass = ALUC_RTYPE;
      OP_BEQ:            aluClass = ALUC_BEQ;
      OP_ANDI:           aluClass = ALUC_ANDI;
      OP_SLTI, OP_SLTIU: aluClass = ALUC_SLT;
      OP_MUL:            aluClass = ALUC_MUL;
      default:           aluClass = ALUC_ADD;
    endcase
  end

  always_comb begin
    ALUOp      = '0;
    ALUOp[2:0] = aluClass;
    ALUOp[3]   = OpCode[0];
  end

endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: FSM sequencing each instruction through
// IF/ID/EX/MEM/WB for the shared multi-cycle MIPS datapath.
// Ports:
//   clk, reset (async, active-high)
//   OpCode, Funct   instruction fields from IR
//   Zero            ALU zero flag (consumed by the datapath via PCWriteCond)
//   mem_ready       memory access completes this cycle
//   PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
//   RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp, ALUOp
//                   datapath controls, combinational on state/OpCode/Funct
//   state_o         current state (debug)
//   illegal_op      one-cycle pulse in ID on an undecoded opcode
//   instr_count     retired-instruction counter (wraps)
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned ALUOP_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic               LuOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state_o,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count
);

  state_t             state, nextState;
  logic               ready;
  logic               retire;
  logic               isRtype, isShift, isJr, isJalr;
  logic [ALUOP_W-1:0] decodedAluOp;

  // Zero gates the PC load inside the datapath; control only raises PCWriteCond.
  logic unusedZero;
  assign unusedZero = Zero;

  assign ready   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign isRtype = (OpCode == OP_RTYPE);
  assign isShift = isRtype && ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA));
  assign isJr    = isRtype && (Funct == FN_JR);
  assign isJalr  = isRtype && (Funct == FN_JALR);
  assign state_o = state;

  mc_alu_op_decode #(.ALUOP_W(ALUOP_W)) aluOpDecode (
    .OpCode (OpCode),
    .ALUOp  (decodedAluOp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IF;
      instr_count <= '0;
    end else begin
      state <= nextState;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nextState   = state;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = DST_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = '0;
    illegal_op  = 1'b0;
    ExtOp       = (OpCode != OP_ANDI);
    LuOp        = (OpCode == OP_LUI);

    case (state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = ready;
        PCWrite = ready;
        if (ready) nextState = S_ID;
      end

      S_ID: begin
        ALUSrcB = SRCB_IMMSH;
        if (!isDecoded(OpCode)) begin
          illegal_op = 1'b1;
          nextState  = S_IF;
        end else if (OpCode == OP_J || OpCode == OP_JAL) begin
          PCWrite   = 1'b1;
          PCSource  = PCSRC_JUMP;
          nextState = S_IF;
          retire    = 1'b1;
          if (OpCode == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            MemtoReg = M2R_PC;
          end
        end else begin
          nextState = S_EX;
        end
      end

      S_EX: begin
        ALUOp = decodedAluOp;
        if (OpCode == OP_BEQ) begin
          ALUSrcA     = SRCA_REGA;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          nextState   = S_IF;
          retire      = 1'b1;
        end else if (isJr || isJalr) begin
          PCWrite   = 1'b1;
          PCSource  = PCSRC_REGA;
          nextState = S_IF;
          retire    = 1'b1;
          if (isJalr) begin
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            MemtoReg = M2R_PC;
          end
        end else if (OpCode == OP_LW || OpCode == OP_SW) begin
          ALUSrcA   = SRCA_REGA;
          ALUSrcB   = SRCB_IMM;
          nextState = S_MEM;
        end else begin
          ALUSrcA   = isShift ? SRCA_SHAMT : SRCA_REGA;
          ALUSrcB   = isImmAlu(OpCode) ? SRCB_IMM : SRCB_REGB;
          nextState = S_WB;
        end
      end

      S_MEM: begin
        IorD = 1'b1;
        if (OpCode == OP_LW) begin
          MemRead = 1'b1;
          if (ready) nextState = S_WB;
        end else begin
          MemWrite = 1'b1;
          if (ready) begin
            nextState = S_IF;
            retire    = 1'b1;
          end
        end
      end

      S_WB: begin
        ALUOp     = decodedAluOp;
        RegWrite  = 1'b1;
        nextState = S_IF;
        retire    = 1'b1;
        if (OpCode == OP_LW) MemtoReg = M2R_MDR;
        else if (isRtype || OpCode == OP_MUL) RegDst = DST_RD;
      end

      default: nextState = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

  logic       clk, reset;
  logic [5:0] OpCode, Funct;
  logic       Zero, mem_ready;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic        ExtOp, LuOp, illegal_op;
  logic [1:0]  PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [3:0]  ALUOp;
  logic [2:0]  state_o;
  logic [31:0] instr_count;

  logic        unused4PCWrite, unused4PCWriteCond, unused4IorD, unused4MemRead;
  logic        unused4MemWrite, unused4IRWrite, unused4RegWrite, unused4ExtOp;
  logic        unused4LuOp, unused4Illegal;
  logic [1:0]  unused4PCSource, unused4RegDst, unused4MemtoReg, unused4SrcA, unused4SrcB;
  logic [3:0]  unused4ALUOp;
  logic [2:0]  unused4State;
  logic [3:0]  count4;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int irw;

  multi_cycle_control #(.MEM_HANDSHAKE(1), .CNT_W(32), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .LuOp(LuOp),
    .ALUOp(ALUOp), .state_o(state_o), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  multi_cycle_control #(.MEM_HANDSHAKE(1), .CNT_W(4), .ALUOP_W(4)) dut4 (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(unused4PCWrite), .PCWriteCond(unused4PCWriteCond),
    .PCSource(unused4PCSource), .IorD(unused4IorD), .MemRead(unused4MemRead),
    .MemWrite(unused4MemWrite), .IRWrite(unused4IRWrite), .RegWrite(unused4RegWrite),
    .RegDst(unused4RegDst), .MemtoReg(unused4MemtoReg), .ALUSrcA(unused4SrcA),
    .ALUSrcB(unused4SrcB), .ExtOp(unused4ExtOp), .LuOp(unused4LuOp),
    .ALUOp(unused4ALUOp), .state_o(unused4State), .illegal_op(unused4Illegal),
    .instr_count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle, tallying IRWrite pulses and elapsed cycles.
  task automatic cyc1();
    irw += int'(IRWrite);
    cyc++;
    tick();
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0; OpCode = 6'h00; Funct = 6'h20;
    #12;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_count", instr_count, 0);
    chk("rst_count4", 32'(count4), 0);
    chk("rst_memread", 32'(MemRead), 1);
    chk("rst_irwrite", 32'(IRWrite), 1);
    chk("rst_alusrcb", 32'(ALUSrcB), 1);
    chk("rst_regwrite", 32'(RegWrite), 0);
    reset = 1'b0;

    // add
    tick();
    chk("add_id_state", 32'(state_o), 1);
    chk("add_id_regwrite", 32'(RegWrite), 0);
    tick();
    chk("add_ex_state", 32'(state_o), 2);
    chk("add_ex_regwrite", 32'(RegWrite), 0);
    chk("add_ex_srca", 32'(ALUSrcA), 1);
    chk("add_ex_aluop", 32'(ALUOp), 4'h2);
    tick();
    chk("add_wb_state", 32'(state_o), 4);
    chk("add_wb_regwrite", 32'(RegWrite), 1);
    chk("add_wb_regdst", 32'(RegDst), 1);
    tick();
    chk("add_done_state", 32'(state_o), 0);
    chk("add_count", instr_count, 1);

    // lw with 3 IF and 2 MEM wait states
    OpCode = 6'h23; mem_ready = 1'b0; cyc = 0; irw = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_if_hold_state", 32'(state_o), 0);
      chk("lw_if_hold_irwrite", 32'(IRWrite), 0);
      chk("lw_if_hold_memread", 32'(MemRead), 1);
      cyc1();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_if_ready_irwrite", 32'(IRWrite), 1);
    cyc1();
    cyc1();
    chk("lw_ex_srcb", 32'(ALUSrcB), 2);
    cyc1();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("lw_mem_hold_state", 32'(state_o), 3);
      chk("lw_mem_iord", 32'(IorD), 1);
      chk("lw_mem_memread", 32'(MemRead), 1);
      chk("lw_mem_regwrite", 32'(RegWrite), 0);
      cyc1();
    end
    mem_ready = 1'b1;
    #1;
    cyc1();
    chk("lw_wb_state", 32'(state_o), 4);
    chk("lw_wb_memtoreg", 32'(MemtoReg), 1);
    chk("lw_wb_regdst", 32'(RegDst), 0);
    chk("lw_wb_regwrite", 32'(RegWrite), 1);
    cyc1();
    chk("lw_cycles", 32'(cyc), 10);
    chk("lw_irwrite_pulses", 32'(irw), 1);
    chk("lw_count", instr_count, 2);

    // beq, Zero=1 then Zero=0
    OpCode = 6'h04; Zero = 1'b1; cyc = 0;
    cyc1(); cyc1();
    chk("beqz_ex_state", 32'(state_o), 2);
    chk("beqz_pcwritecond", 32'(PCWriteCond), 1);
    chk("beqz_pcsource", 32'(PCSource), 1);
    chk("beqz_aluop", 32'(ALUOp), 4'h1);
    cyc1();
    chk("beqz_cycles", 32'(cyc), 3);
    chk("beqz_count", instr_count, 3);
    Zero = 1'b0; cyc = 0;
    cyc1(); cyc1();
    chk("beqn_pcwritecond", 32'(PCWriteCond), 1);
    chk("beqn_pcsource", 32'(PCSource), 1);
    cyc1();
    chk("beqn_state", 32'(state_o), 0);
    chk("beqn_cycles", 32'(cyc), 3);
    chk("beqn_count", instr_count, 4);

    // jal
    OpCode = 6'h03;
    tick();
    chk("jal_id_pcwrite", 32'(PCWrite), 1);
    chk("jal_id_pcsource", 32'(PCSource), 2);
    chk("jal_id_regwrite", 32'(RegWrite), 1);
    chk("jal_id_regdst", 32'(RegDst), 2);
    chk("jal_id_memtoreg", 32'(MemtoReg), 2);
    tick();
    chk("jal_done_state", 32'(state_o), 0);
    chk("jal_count", instr_count, 5);

    // undecoded opcode
    OpCode = 6'h3f;
    tick();
    chk("ill_id_state", 32'(state_o), 1);
    chk("ill_pulse", 32'(illegal_op), 1);
    chk("ill_pcwrite", 32'(PCWrite), 0);
    chk("ill_pcwritecond", 32'(PCWriteCond), 0);
    chk("ill_regwrite", 32'(RegWrite), 0);
    chk("ill_memwrite", 32'(MemWrite), 0);
    chk("ill_irwrite", 32'(IRWrite), 0);
    tick();
    chk("ill_done_state", 32'(state_o), 0);
    chk("ill_pulse_end", 32'(illegal_op), 0);
    chk("ill_count", instr_count, 5);

    // andi
    OpCode = 6'h0c;
    tick(); tick();
    chk("andi_extop", 32'(ExtOp), 0);
    chk("andi_aluop", 32'(ALUOp), 4'h4);
    chk("andi_srcb", 32'(ALUSrcB), 2);
    tick();
    chk("andi_wb_regwrite", 32'(RegWrite), 1);
    chk("andi_wb_regdst", 32'(RegDst), 0);
    chk("andi_wb_memtoreg", 32'(MemtoReg), 0);
    tick();
    chk("andi_count", instr_count, 6);

    // sll uses shamt on ALU port A
    OpCode = 6'h00; Funct = 6'h00;
    tick(); tick();
    chk("sll_srca", 32'(ALUSrcA), 2);
    tick(); tick();
    chk("sll_count", instr_count, 7);

    // jr
    Funct = 6'h08;
    tick(); tick();
    chk("jr_pcwrite", 32'(PCWrite), 1);
    chk("jr_pcsource", 32'(PCSource), 3);
    chk("jr_regwrite", 32'(RegWrite), 0);
    tick();
    chk("jr_state", 32'(state_o), 0);
    chk("jr_count", instr_count, 8);

    // sltiu: class 101 with OpCode[0]=1
    OpCode = 6'h0b;
    tick(); tick();
    chk("sltiu_aluop", 32'(ALUOp), 4'hd);
    chk("sltiu_extop", 32'(ExtOp), 1);
    tick(); tick();
    chk("sltiu_count", instr_count, 9);

    // run j instructions up to the 4-bit counter wrap
    OpCode = 6'h02;
    for (int i = 0; i < 6; i++) begin
      tick(); tick();
    end
    chk("wrap_count4_max", 32'(count4), 15);
    tick(); tick();
    chk("wrap_count4_zero", 32'(count4), 0);
    chk("wrap_count32", instr_count, 16);

    // sw interrupted by reset while stalled in MEM
    OpCode = 6'h2b;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    chk("sw_mem_state", 32'(state_o), 3);
    chk("sw_mem_memwrite", 32'(MemWrite), 1);
    chk("sw_mem_iord", 32'(IorD), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("swrst_state", 32'(state_o), 0);
    chk("swrst_memwrite", 32'(MemWrite), 0);
    chk("swrst_count", instr_count, 0);
    chk("swrst_count4", 32'(count4), 0);
    tick();
    chk("swrst_hold_state", 32'(state_o), 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
